// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR sequencer.
//   state_e      : sequencer FSM states
//   MAX_NUM_BITS : widest supported LFSR
//   lfsr_taps()  : XNOR feedback tap mask for a given LFSR width (bit k-1 = tap k)
//   lfsr_period(): maximal-length period 2^n-1 for a given LFSR width
package lfsr_pkg;

    localparam int unsigned MAX_NUM_BITS = 32;
    localparam int unsigned PERIOD_W     = MAX_NUM_BITS + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEED = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Maximal-length XNOR tap sets for widths 3..32.
    function automatic logic [MAX_NUM_BITS-1:0] lfsr_taps(input int unsigned n);
        logic [MAX_NUM_BITS-1:0] taps;
        case (n)
            3:       taps = 32'h0000_0006;
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0829;
            13:      taps = 32'h0000_100D;
            14:      taps = 32'h0000_2015;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_D008;
            17:      taps = 32'h0001_2000;
            18:      taps = 32'h0002_0400;
            19:      taps = 32'h0004_0023;
            20:      taps = 32'h0009_0000;
            21:      taps = 32'h0014_0000;
            22:      taps = 32'h0030_0000;
            23:      taps = 32'h0042_0000;
            24:      taps = 32'h00E1_0000;
            25:      taps = 32'h0120_0000;
            26:      taps = 32'h0200_0023;
            27:      taps = 32'h0400_0013;
            28:      taps = 32'h0900_0000;
            29:      taps = 32'h1400_0000;
            30:      taps = 32'h2000_0029;
            31:      taps = 32'h4800_0000;
            32:      taps = 32'h8020_0003;
            default: taps = 32'h0000_0006;
        endcase
        return taps;
    endfunction

    // Period of a maximal-length n-bit LFSR.
    function automatic logic [MAX_NUM_BITS-1:0] lfsr_period(input int unsigned n);
        logic [PERIOD_W-1:0] one;
        logic [PERIOD_W-1:0] p;
        one = PERIOD_W'(1);
        p   = one << n;
        return MAX_NUM_BITS'(p - one);
    endfunction

endpackage

// File: rtl/lfsr_seq_ctrl_lfsr.sv
// XNOR-feedback Fibonacci LFSR with synchronous seed load.
//   i_Clk, i_Rst_L : clock, async active-low reset (register clears to 0)
//   i_Enable       : step (or load, when i_Seed_DV) on this edge
//   i_Seed_DV      : load i_Seed_Data instead of shifting
//   i_Seed_Data    : seed value; also the reference for o_LFSR_Done
//   o_LFSR_Data    : current LFSR word
//   o_LFSR_Done    : current word equals i_Seed_Data
module lfsr_seq_ctrl_lfsr
    import lfsr_pkg::*;
#(
    parameter int unsigned NUM_BITS = 3
) (
    input  logic                i_Clk,
    input  logic                i_Rst_L,
    input  logic                i_Enable,
    input  logic                i_Seed_DV,
    input  logic [NUM_BITS-1:0] i_Seed_Data,
    output logic [NUM_BITS-1:0] o_LFSR_Data,
    output logic                o_LFSR_Done
);

    localparam logic [NUM_BITS-1:0] TAPS = NUM_BITS'(lfsr_taps(NUM_BITS));

    logic [NUM_BITS-1:0] lfsr_q;
    logic                feedback;

    // XNOR of all tapped bits; all-ones is the lockup state.
    assign feedback = ~^(lfsr_q & TAPS);

    // Shift register: load seed or shift left inserting feedback.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            lfsr_q <= '0;
        end else if (i_Enable) begin
            if (i_Seed_DV) begin
                lfsr_q <= i_Seed_Data;
            end else begin
                lfsr_q <= {lfsr_q[NUM_BITS-2:0], feedback};
            end
        end
    end

    assign o_LFSR_Data = lfsr_q;
    assign o_LFSR_Done = (lfsr_q == i_Seed_Data);

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Command-driven sequencer around one LFSR: accepts {seed, count}, seeds the
// LFSR, then streams exactly count words with backpressure. The LFSR steps
// only when a word is accepted downstream.
// Optional feature macro: LFSR_PERIOD_CHECK_EN adds o_Period_Err, a sticky
// flag set when the distance from the first word to the first wrap word is
// not 2^NUM_BITS-1.
//   i_Clk, i_Rst_L          : clock, async active-low reset
//   i_Cmd_DV / o_Cmd_Ready  : command handshake (ready only in IDLE)
//   i_Cmd_Seed, i_Cmd_Count : command payload, latched on accept
//   o_Out_DV / i_Out_Ready  : output word handshake
//   o_Out_Data              : current LFSR word
//   o_Out_Wrap              : word equals seed and is not the first word
//   o_Busy                  : not IDLE
//   o_Done                  : one-cycle pulse on command completion
//   o_Seed_Fix              : one-cycle pulse, all-ones seed replaced by zero
//   o_Period_Err            : (LFSR_PERIOD_CHECK_EN only) sticky period error
module lfsr_seq_ctrl
    import lfsr_pkg::*;
#(
    parameter int unsigned NUM_BITS = 3,
    parameter int unsigned CNT_BITS = 16
) (
    input  logic                i_Clk,
    input  logic                i_Rst_L,
    input  logic                i_Cmd_DV,
    output logic                o_Cmd_Ready,
    input  logic [NUM_BITS-1:0] i_Cmd_Seed,
    input  logic [CNT_BITS-1:0] i_Cmd_Count,
    output logic                o_Out_DV,
    input  logic                i_Out_Ready,
    output logic [NUM_BITS-1:0] o_Out_Data,
    output logic                o_Out_Wrap,
    output logic                o_Busy,
    output logic                o_Done,
    output logic                o_Seed_Fix
`ifdef LFSR_PERIOD_CHECK_EN
    ,
    output logic                o_Period_Err
`endif
);

    state_e              state_q;
    state_e              state_d;
    logic                cmd_accept;
    logic                out_accept;
    logic                seed_is_lock;
    logic                lfsr_seed_dv;
    logic                lfsr_enable;
    logic                lfsr_done;
    logic [NUM_BITS-1:0] lfsr_data;
    logic [NUM_BITS-1:0] seed_q;
    logic [CNT_BITS-1:0] cnt_q;
    logic                first_q;

    // Next-state and LFSR control.
    always_comb begin
        state_d      = state_q;
        cmd_accept   = o_Cmd_Ready && i_Cmd_DV;
        out_accept   = o_Out_DV && i_Out_Ready;
        seed_is_lock = (i_Cmd_Seed == '1);
        lfsr_seed_dv = 1'b0;
        lfsr_enable  = out_accept;
        case (state_q)
            IDLE: begin
                if (cmd_accept) begin
                    state_d = (i_Cmd_Count == '0) ? DONE : SEED;
                end
            end
            SEED: begin
                lfsr_seed_dv = 1'b1;
                lfsr_enable  = 1'b1;
                state_d      = RUN;
            end
            RUN: begin
                if (out_accept && (cnt_q == CNT_BITS'(1))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; status outputs are registered decodes of the next state.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q     <= IDLE;
            o_Cmd_Ready <= 1'b1;
            o_Busy      <= 1'b0;
            o_Out_DV    <= 1'b0;
            o_Done      <= 1'b0;
            o_Seed_Fix  <= 1'b0;
        end else begin
            state_q     <= state_d;
            o_Cmd_Ready <= (state_d == IDLE);
            o_Busy      <= (state_d != IDLE);
            o_Out_DV    <= (state_d == RUN);
            o_Done      <= (state_d == DONE);
            o_Seed_Fix  <= cmd_accept && seed_is_lock;
        end
    end

    // Command payload, remaining-word counter and first-word marker.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            seed_q  <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
        end else begin
            if (cmd_accept) begin
                seed_q <= seed_is_lock ? '0 : i_Cmd_Seed;
                cnt_q  <= i_Cmd_Count;
            end else if (out_accept) begin
                cnt_q <= cnt_q - CNT_BITS'(1);
            end
            if (state_q == SEED) begin
                first_q <= 1'b1;
            end else if (out_accept) begin
                first_q <= 1'b0;
            end
        end
    end

    // Seed stays on the LFSR for the whole command so o_LFSR_Done marks wraps.
    lfsr_seq_ctrl_lfsr #(
        .NUM_BITS (NUM_BITS)
    ) u_lfsr (
        .i_Clk       (i_Clk),
        .i_Rst_L     (i_Rst_L),
        .i_Enable    (lfsr_enable),
        .i_Seed_DV   (lfsr_seed_dv),
        .i_Seed_Data (seed_q),
        .o_LFSR_Data (lfsr_data),
        .o_LFSR_Done (lfsr_done)
    );

    assign o_Out_Data = lfsr_data;
    assign o_Out_Wrap = lfsr_done && !first_q && o_Out_DV;

`ifdef LFSR_PERIOD_CHECK_EN
    localparam logic [NUM_BITS-1:0] PERIOD = NUM_BITS'(lfsr_period(NUM_BITS));

    logic [NUM_BITS-1:0] period_cnt_q;
    logic                period_checked_q;

    // Accepts from the first word up to the first wrap word, checked once per command.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            period_cnt_q     <= '0;
            period_checked_q <= 1'b0;
            o_Period_Err     <= 1'b0;
        end else if (state_q == SEED) begin
            period_cnt_q     <= '0;
            period_checked_q <= 1'b0;
        end else if (o_Out_DV && !period_checked_q) begin
            if (o_Out_Wrap) begin
                period_checked_q <= 1'b1;
                if (period_cnt_q != PERIOD) begin
                    o_Period_Err <= 1'b1;
                end
            end else if (out_accept) begin
                period_cnt_q <= period_cnt_q + NUM_BITS'(1);
            end
        end
    end
`else
    // Period checker not built.
`endif

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl at NUM_BITS=3 with a hand-written
// reference sequence for seed 000.
module tb_lfsr_seq_ctrl;

    localparam int unsigned NB = 3;
    localparam int unsigned CB = 16;

    logic          clk;
    logic          rst_n;
    logic          cmd_dv;
    logic          cmd_ready;
    logic [NB-1:0] cmd_seed;
    logic [CB-1:0] cmd_count;
    logic          out_dv;
    logic          out_ready;
    logic [NB-1:0] out_data;
    logic          out_wrap;
    logic          busy;
    logic          done;
    logic          seed_fix;
`ifdef LFSR_PERIOD_CHECK_EN
    logic          period_err;
`endif

    int errors;
    int checks;

    // Hand-computed 3-bit XNOR sequence starting from 000.
    logic [2:0] seq [7];

    lfsr_seq_ctrl #(
        .NUM_BITS (NB),
        .CNT_BITS (CB)
    ) dut (
        .i_Clk        (clk),
        .i_Rst_L      (rst_n),
        .i_Cmd_DV     (cmd_dv),
        .o_Cmd_Ready  (cmd_ready),
        .i_Cmd_Seed   (cmd_seed),
        .i_Cmd_Count  (cmd_count),
        .o_Out_DV     (out_dv),
        .i_Out_Ready  (out_ready),
        .o_Out_Data   (out_data),
        .o_Out_Wrap   (out_wrap),
        .o_Busy       (busy),
        .o_Done       (done),
        .o_Seed_Fix   (seed_fix)
`ifdef LFSR_PERIOD_CHECK_EN
        ,
        .o_Period_Err (period_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a command at T; returns at T+2.
    task automatic do_cmd(input logic [2:0] seed, input int count, input logic exp_fix, input logic hold);
        cmd_dv    = 1'b1;
        cmd_seed  = seed;
        cmd_count = CB'(count);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        tick();
        if (!hold) cmd_dv = 1'b0;
        check("seed_fix_t1", 32'(seed_fix), 32'(exp_fix));
        check("busy_t1", 32'(busy), 32'd1);
        check("cmd_ready_t1", 32'(cmd_ready), 32'd0);
        check("out_dv_t1", 32'(out_dv), 32'd0);
        check("done_t1", 32'(done), 32'(count == 0));
        tick();
        check("seed_fix_t2", 32'(seed_fix), 32'd0);
    endtask

    // Consume count words starting at seq[start]; ends in the IDLE cycle after DONE.
    task automatic run_stream(input int start, input int count, input logic [7:0] rdy, input int rdy_len);
        int   seen;
        int   cyc;
        logic r;
        seen = 0;
        cyc  = 0;
        while (seen < count && cyc < 64) begin
            r = (cyc < rdy_len) ? rdy[cyc] : 1'b1;
            out_ready = r;
            check("out_dv", 32'(out_dv), 32'd1);
            check("out_data", 32'(out_data), 32'(seq[(start + seen) % 7]));
            check("out_wrap", 32'(out_wrap), 32'(seen > 0 && (seen % 7) == 0));
            check("cmd_ready_run", 32'(cmd_ready), 32'd0);
            check("done_run", 32'(done), 32'd0);
            if (r && out_dv) seen++;
            tick();
            cyc++;
        end
        check("word_count", 32'(seen), 32'(count));
        out_ready = 1'b1;
        check("out_dv_done", 32'(out_dv), 32'd0);
        check("done_pulse", 32'(done), 32'd1);
        check("cmd_ready_done", 32'(cmd_ready), 32'd0);
        tick();
        check("done_clear", 32'(done), 32'd0);
        check("cmd_ready_back", 32'(cmd_ready), 32'd1);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        errors    = 0;
        checks    = 0;
        seq[0] = 3'b000; seq[1] = 3'b001; seq[2] = 3'b011; seq[3] = 3'b110;
        seq[4] = 3'b101; seq[5] = 3'b010; seq[6] = 3'b100;
        rst_n     = 1'b1;
        cmd_dv    = 1'b0;
        cmd_seed  = '0;
        cmd_count = '0;
        out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_out_dv", 32'(out_dv), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_seed_fix", 32'(seed_fix), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_wrap", 32'(out_wrap), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1: full period, no wrap
        do_cmd(3'b000, 7, 1'b0, 1'b0);
        run_stream(0, 7, 8'hFF, 0);
        tick();

        // 2: past the period, wrap on 8th word
        do_cmd(3'b000, 9, 1'b0, 1'b0);
        run_stream(0, 9, 8'hFF, 0);
`ifdef LFSR_PERIOD_CHECK_EN
        check("period_err", 32'(period_err), 32'd0);
`endif
        tick();

        // 3: backpressure pattern 1,0,0,1,1
        do_cmd(3'b011, 3, 1'b0, 1'b0);
        run_stream(2, 3, 8'b0001_1001, 5);
        tick();

        // 4: lockup seed replaced by zero
        do_cmd(3'b111, 2, 1'b1, 1'b0);
        run_stream(0, 2, 8'hFF, 0);
        tick();

        // 5: zero count
        do_cmd(3'b010, 0, 1'b0, 1'b0);
        check("zero_cmd_ready", 32'(cmd_ready), 32'd1);
        check("zero_done", 32'(done), 32'd0);
        check("zero_out_dv", 32'(out_dv), 32'd0);
        check("zero_busy", 32'(busy), 32'd0);
        tick();

        // 6: reset mid-stream with command valid held
        do_cmd(3'b000, 5, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            check("abort_data", 32'(out_data), 32'(seq[k]));
            check("abort_cmd_ready", 32'(cmd_ready), 32'd0);
            tick();
        end
        check("abort_data3", 32'(out_data), 32'(seq[2]));
        check("abort_cmd_ready3", 32'(cmd_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_dv", 32'(out_dv), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_data", 32'(out_data), 32'd0);
        check("mid_rst_wrap", 32'(out_wrap), 32'd0);
        tick();
        check("mid_rst_no_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();
        check("reaccept_busy", 32'(busy), 32'd1);
        check("reaccept_cmd_ready", 32'(cmd_ready), 32'd0);
        check("reaccept_out_dv", 32'(out_dv), 32'd0);
        check("reaccept_done", 32'(done), 32'd0);
        tick();
        run_stream(0, 5, 8'hFF, 0);
        cmd_dv = 1'b0;
        tick();
        tick();
        check("final_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
